alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: ALU operand and result width.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 2 bits: per-requester operation request.
REQ-005 SHALL have port req_ready, output, 2 bits: per-requester accept, at most one bit set.
REQ-006 SHALL have port req_dataIn0, input, 2*DATA_W bits: operand A; requester i uses bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port req_dataIn1, input, 2*DATA_W bits: operand B, packed as req_dataIn0.
REQ-008 SHALL have port req_shamt, input, 10 bits: 5-bit shift amount per requester.
REQ-009 SHALL have port req_funct, input, 12 bits: 6-bit funct code per requester.
REQ-010 SHALL have port rsp_valid, output, 2 bits: result valid, one-hot to the owning requester.
REQ-011 SHALL have port rsp_ready, input, 2 bits: per-requester response accept.
REQ-012 SHALL have port rsp_result, output, DATA_W bits: registered ALU result.
REQ-013 SHALL have port rsp_flags, output, 3 bits: registered {zero, negative, positive}.
REQ-014 SHALL have ports alu_dataIn0/alu_dataIn1 (DATA_W), alu_shamt (5), alu_funct (6), all outputs, driving the shared ALU.
REQ-015 SHALL have ports alu_result (DATA_W) and alu_flags (3, {outputZero, outputNegative, outputPositive}), inputs from the ALU.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> HOLD -> IDLE.
REQ-017 In IDLE, SHALL assert req_ready only for the granted requester, combinationally from req_valid; no grant when req_valid == 0.
REQ-018 On req_valid[g] & req_ready[g], SHALL register operands, shamt, funct and owner g, then go to ISSUE.
REQ-019 SHALL drive alu_* from the operand registers in every state; ALU inputs change only on acceptance.
REQ-020 In ISSUE (one cycle), SHALL capture alu_result/alu_flags into rsp registers and go to HOLD.
REQ-021 In HOLD, SHALL assert rsp_valid[owner] and hold rsp_result/rsp_flags stable until rsp_ready[owner]; rsp_ready of the non-owner is ignored.
REQ-022 On the response handshake, SHALL return to IDLE; a new request is accepted no earlier than the next cycle.
REQ-023 Latency: rsp_valid rises exactly 2 cycles after the accepting edge; minimum 3 cycles per operation.
REQ-024 req_ready SHALL be 0 in ISSUE and HOLD; requests are held by requesters, never dropped or queued.
REQ-025 Requests arriving in ISSUE/HOLD SHALL be arbitrated in the next IDLE cycle.

Reset
REQ-026 On rst: state IDLE, req_ready 0, rsp_valid 0, rsp_result 0, rsp_flags 0, operand/funct/shamt registers 0, last-grant pointer 1.
REQ-027 Reset mid-operation SHALL discard the transaction; no response is issued.

Configuration
REQ-028 With ALU_ARB_ROUND_ROBIN_EN defined, SHALL grant, on simultaneous requests, the requester other than the last granted one, updating the pointer on each acceptance.
REQ-029 Without ALU_ARB_ROUND_ROBIN_EN, SHALL use fixed priority, requester 0 always winning.

Structure
REQ-030 Package alu_arb_pkg SHALL hold the FSM state enum, DATA_W default, FUNCT_W=6, SHAMT_W=5 and NUM_REQ=2.
REQ-031 Grant logic SHALL be sub-module alu_arb_grant (req_valid, last-grant pointer -> one-hot grant).

Verification
REQ-032 req0 only: A=5, B=3, funct=0x20 (add) -> rsp_valid=01 two cycles after acceptance, rsp_result=8, rsp_flags=3'b001.
REQ-033 req1 only: A=3, B=5, funct=0x22 (sub) -> rsp_valid=10, rsp_result=0xFFFFFFFE, rsp_flags=3'b010.
REQ-034 Both valid continuously with round-robin enabled -> grants alternate 0,1,0,1; disabled -> req0 always served and req1 starves.
REQ-035 rsp_ready held low 4 cycles, req_valid=11 -> rsp_result/rsp_flags stable, req_ready=00 throughout.
REQ-036 rst asserted in ISSUE -> rsp_valid never rises, all outputs return to reset values, next request completes normally.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and sizes for the two-requester ALU arbiter.
// Consumers: alu_arb_grant, alu_arbiter.
package alu_arb_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int FUNCT_W        = 6;
  localparam int SHAMT_W        = 5;
  localparam int NUM_REQ        = 2;
  localparam int FLAGS_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_t;

  // Index of the set bit in a one-hot grant vector (two requesters).
  function automatic logic grant_index(input logic [NUM_REQ-1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// One-hot grant selection between two requesters.
// ALU_ARB_ROUND_ROBIN_EN selects alternating grants on contention; default is fixed priority (requester 0 wins).
module alu_arb_grant
  import alu_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic               i_last_grant,
  output logic [NUM_REQ-1:0] o_grant
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // On contention the requester that was not served last time wins.
  always_comb begin
    o_grant = '0;
    if (&i_req_valid) begin
      o_grant[~i_last_grant] = 1'b1;
    end else begin
      o_grant = i_req_valid;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last_grant;

  always_comb begin
    o_grant = '0;
    if (i_req_valid[0]) begin
      o_grant[0] = 1'b1;
    end else if (i_req_valid[1]) begin
      o_grant[1] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: accept, issue for one cycle, hold the result until the owner takes it.
// Optional macro ALU_ARB_ROUND_ROBIN_EN switches contention handling from fixed priority to round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_dataIn0,
  input  logic [NUM_REQ*DATA_W-1:0]   req_dataIn1,
  input  logic [NUM_REQ*SHAMT_W-1:0]  req_shamt,
  input  logic [NUM_REQ*FUNCT_W-1:0]  req_funct,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [DATA_W-1:0]           rsp_result,
  output logic [FLAGS_W-1:0]          rsp_flags,
  output logic [DATA_W-1:0]           alu_dataIn0,
  output logic [DATA_W-1:0]           alu_dataIn1,
  output logic [SHAMT_W-1:0]          alu_shamt,
  output logic [FUNCT_W-1:0]          alu_funct,
  input  logic [DATA_W-1:0]           alu_result,
  input  logic [FLAGS_W-1:0]          alu_flags
);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic                 r_last;
  logic                 r_owner;
  logic [DATA_W-1:0]    r_op_a;
  logic [DATA_W-1:0]    r_op_b;
  logic [SHAMT_W-1:0]   r_shamt;
  logic [FUNCT_W-1:0]   r_funct;
  logic [DATA_W-1:0]    r_rsp_result;
  logic [FLAGS_W-1:0]   r_rsp_flags;

  logic [NUM_REQ-1:0]   w_grant;
  logic [NUM_REQ-1:0]   w_req_ready;
  logic [NUM_REQ-1:0]   w_rsp_valid;
  logic                 w_accept;
  logic                 w_gidx;

  logic [DATA_W-1:0]    w_a     [NUM_REQ];
  logic [DATA_W-1:0]    w_b     [NUM_REQ];
  logic [SHAMT_W-1:0]   w_shamt [NUM_REQ];
  logic [FUNCT_W-1:0]   w_funct [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a[gi]     = req_dataIn0[gi*DATA_W  +: DATA_W];
    assign w_b[gi]     = req_dataIn1[gi*DATA_W  +: DATA_W];
    assign w_shamt[gi] = req_shamt[gi*SHAMT_W   +: SHAMT_W];
    assign w_funct[gi] = req_funct[gi*FUNCT_W   +: FUNCT_W];
  end

  alu_arb_grant u_grant (
    .i_req_valid  (req_valid),
    .i_last_grant (r_last),
    .o_grant      (w_grant)
  );

  assign w_gidx = grant_index(w_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grants are only offered while idle; the owner's rsp_ready alone ends HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_rsp_valid = '0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = w_grant;
        w_accept    = |(w_grant & req_valid);
        if (w_accept) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_rsp_valid[r_owner] = 1'b1;
        if (rsp_ready[r_owner]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture on acceptance; ALU result capture at the end of ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_shamt      <= '0;
      r_funct      <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_op_a  <= w_a[w_gidx];
        r_op_b  <= w_b[w_gidx];
        r_shamt <= w_shamt[w_gidx];
        r_funct <= w_funct[w_gidx];
        r_owner <= w_gidx;
        r_last  <= w_gidx;
      end
      if (r_state == ST_ISSUE) begin
        r_rsp_result <= alu_result;
        r_rsp_flags  <= alu_flags;
      end
    end
  end

  assign req_ready   = rst ? '0 : w_req_ready;
  assign rsp_valid   = w_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_flags   = r_rsp_flags;
  assign alu_dataIn0 = r_op_a;
  assign alu_dataIn1 = r_op_b;
  assign alu_shamt   = r_shamt;
  assign alu_funct   = r_funct;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, transaction-level reference model and directed plus random stimulus.
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*DW-1:0] req_dataIn0, req_dataIn1;
  logic [9:0]      req_shamt;
  logic [11:0]     req_funct;
  logic [DW-1:0]   rsp_result, alu_dataIn0, alu_dataIn1, alu_result;
  logic [2:0]      rsp_flags, alu_flags;
  logic [4:0]      alu_shamt;
  logic [5:0]      alu_funct;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dataIn0(req_dataIn0), .req_dataIn1(req_dataIn1),
    .req_shamt(req_shamt), .req_funct(req_funct),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_dataIn0(alu_dataIn0), .alu_dataIn1(alu_dataIn1),
    .alu_shamt(alu_shamt), .alu_funct(alu_funct),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh, input logic [5:0] fn);
    case (fn)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h00:   return b << sh;
      6'h02:   return b >> sh;
      6'h03:   return 32'($signed(b) >>> sh);
      6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] ref_flags(input logic [31:0] r);
    return {r == 32'd0, r[31], (r != 32'd0) && !r[31]};
  endfunction

  function automatic logic [1:0] mdl_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      return last ? 2'b01 : 2'b10;
`else
      return 2'b01;
`endif
    end
    return v;
  endfunction

  always_comb begin
    alu_result = ref_alu(alu_dataIn0, alu_dataIn1, alu_shamt, alu_funct);
    alu_flags  = ref_flags(alu_result);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks one transaction by its age since acceptance.
  initial begin
    logic        m_busy, m_owner, m_last, g;
    int          m_age;
    logic [31:0] m_a, m_b, m_res;
    logic [4:0]  m_sh;
    logic [5:0]  m_fn;
    logic [2:0]  m_fl;
    logic [1:0]  exp_ready, exp_rv;
    m_busy = 0; m_owner = 0; m_last = 1; m_age = 0;
    m_a = 0; m_b = 0; m_sh = 0; m_fn = 0; m_res = 0; m_fl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_flags", rsp_flags, 3'd0);
        chk("rst_alu_a", alu_dataIn0, 32'd0);
        chk("rst_alu_b", alu_dataIn1, 32'd0);
        chk("rst_alu_op", {alu_shamt, alu_funct}, 11'd0);
        m_busy = 0; m_owner = 0; m_last = 1; m_age = 0;
        m_a = 0; m_b = 0; m_sh = 0; m_fn = 0; m_res = 0; m_fl = 0;
      end else begin
        exp_ready = m_busy ? 2'b00 : mdl_grant(req_valid, m_last);
        exp_rv    = (m_busy && m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", req_ready, exp_ready);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_flags", rsp_flags, m_fl);
        chk("alu_a", alu_dataIn0, m_a);
        chk("alu_b", alu_dataIn1, m_b);
        chk("alu_op", {alu_shamt, alu_funct}, {m_sh, m_fn});
        if (!m_busy) begin
          if (exp_ready != 2'b00) begin
            g       = exp_ready[1];
            m_a     = req_dataIn0[g*DW +: DW];
            m_b     = req_dataIn1[g*DW +: DW];
            m_sh    = req_shamt[g*5 +: 5];
            m_fn    = req_funct[g*6 +: 6];
            m_owner = g;
            m_last  = g;
            m_busy  = 1;
            m_age   = 1;
          end
        end else if (m_age == 1) begin
          m_res = ref_alu(m_a, m_b, m_sh, m_fn);
          m_fl  = ref_flags(m_res);
          m_age = 2;
        end else if (rsp_ready[m_owner]) begin
          m_busy = 0;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [5:0] fn);
    req_dataIn0[i*DW +: DW] = a;
    req_dataIn1[i*DW +: DW] = b;
    req_shamt[i*5 +: 5]     = sh;
    req_funct[i*6 +: 6]     = fn;
  endtask

  task automatic wait_accept(input int idx, input string nm);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[idx] && t < 20);
    chk(nm, req_ready[idx], 1'b1);
  endtask

  // Single operation with literal expectations; starts and ends just after a rising edge with the DUT idle.
  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [5:0] fn,
                       input logic [31:0] er, input logic [2:0] ef);
    int t = 0;
    logic [1:0] oh;
    oh = (idx == 1) ? 2'b10 : 2'b01;
    set_req(idx, a, b, sh, fn);
    req_valid = oh;
    rsp_ready = 2'b00;
    wait_accept(idx, "op_accept");
    @(posedge clk); #1;
    req_valid = 2'b00;
    do begin
      @(negedge clk);
      t++;
    end while (rsp_valid == 2'b00 && t < 20);
    chk("op_latency", 64'(t), 64'd2);
    chk("op_rsp_valid", rsp_valid, oh);
    chk("op_result", rsp_result, er);
    chk("op_flags", rsp_flags, ef);
    @(posedge clk); #1;
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
  endtask

  initial begin
    int t;
    int g[$];
    logic [1:0] acc;
    logic [1:0] exp_next;
    logic [5:0] codes [10];
    codes = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h2A};

    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_dataIn0 = '0; req_dataIn1 = '0; req_shamt = '0; req_funct = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_op(0, 32'd5, 32'd3, 5'd0, 6'h20, 32'd8, 3'b001);
    do_op(1, 32'd3, 32'd5, 5'd0, 6'h22, 32'hFFFF_FFFE, 3'b010);
    do_op(0, 32'd5, 32'd5, 5'd0, 6'h22, 32'd0, 3'b100);
    do_op(1, 32'hF0, 32'h3C, 5'd0, 6'h24, 32'h30, 3'b001);
    do_op(0, 32'd0, 32'd1, 5'd31, 6'h00, 32'h8000_0000, 3'b010);
    do_op(1, 32'd0, 32'h8000_0000, 5'd4, 6'h03, 32'hF800_0000, 3'b010);

    // Contention: both requesters valid for four operations after a fresh reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_req(0, 32'd10, 32'd1, 5'd0, 6'h20);
    set_req(1, 32'd20, 32'd2, 5'd0, 6'h22);
    req_valid = 2'b11; rsp_ready = 2'b11;
    t = 0;
    while (g.size() < 4 && t < 60) begin
      @(negedge clk);
      t++;
      if (req_ready != 2'b00) g.push_back(int'(req_ready[1]));
    end
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1 rsp_ready = 2'b00;
    chk("contend_count", 64'(g.size()), 64'd4);
    for (int k = 0; k < g.size(); k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      chk("contend_grant", 64'(g[k]), 64'(k % 2));
`else
      chk("contend_grant", 64'(g[k]), 64'd0);
`endif
    end

    // Backpressure: owner withholds rsp_ready, non-owner asserts it, both requesters valid.
    set_req(0, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd0, 6'h26);
    set_req(1, 32'd1, 32'd2, 5'd0, 6'h20);
    req_valid = 2'b01; rsp_ready = 2'b00;
    wait_accept(0, "hold_accept");
    @(posedge clk); #1;
    req_valid = 2'b11; rsp_ready = 2'b10;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (rsp_valid == 2'b00 && t < 20);
    for (int k = 0; k < 4; k++) begin
      chk("hold_rsp_valid", rsp_valid, 2'b01);
      chk("hold_result", rsp_result, 32'h5A5A_A5A5);
      chk("hold_flags", rsp_flags, 3'b001);
      chk("hold_req_ready", req_ready, 2'b00);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 2'b01;
    @(posedge clk); #1 rsp_ready = 2'b00;
    @(negedge clk);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_next = 2'b10;
`else
    exp_next = 2'b01;
`endif
    chk("hold_next_grant", req_ready, exp_next);
    @(posedge clk); #1 req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (5) @(posedge clk);
    #1 rsp_ready = 2'b00;

    // Reset while the ALU is being sampled: the transaction must vanish.
    set_req(0, 32'd7, 32'd8, 5'd0, 6'h20);
    req_valid = 2'b01;
    wait_accept(0, "rst_accept");
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
    @(negedge clk);
    chk("rst_mid_rsp_valid", rsp_valid, 2'b00);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 2'b00);
    end
    @(posedge clk); #1 rsp_ready = 2'b00;
    do_op(1, 32'd100, 32'd1, 5'd0, 6'h22, 32'd99, 3'b001);

    // Random traffic: requests held until accepted, random response backpressure, rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_req(i,
                  ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom),
                  ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom),
                  5'($urandom),
                  ($urandom_range(0, 15) == 0) ? 6'($urandom) : codes[$urandom_range(0, 9)]);
        end
      end
      rsp_ready = 2'($urandom);
    end
    req_valid = 2'b00; rsp_ready = 2'b11; rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
